// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Purpose  : Run/halt/single-step clock controller for the 8-bit computer.
//            Turns the board push-buttons and the CPU halt request into a
//            one-cycle CPU clock-enable pulse, either at a divided rate
//            (slow or fast) while running, or one pulse per step press.
//
// Ports    : CLOCK_50   in   board clock, all logic on its rising edge
//            reset      in   synchronous, active-high
//            key_run    in   raw button, press toggles run/halt
//            key_step   in   raw button, press gives one step while halted
//            key_speed  in   raw button, press toggles slow/fast
//            halt_req   in   level halt request from the CPU HLT decode
//            cpu_ce     out  registered one-cycle clock-enable to the CPU
//            running    out  registered, high while in RUNNING
//            fast       out  registered speed mode (1 = DIV_FAST)
//            ce_led     out  registered, toggles on every cpu_ce
//            cyc_count  out  number of cpu_ce pulses since reset (wraps)
//
// Config   : CPU_CLOCK_CTRL_DEBOUNCE_EN - when defined, each key has a
//            DEBOUNCE_CYCLES debouncer; when undefined the debouncers are
//            removed and the synchronizer output is used directly.
//
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clock_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DIV_WIDTH       = 16,
    parameter int unsigned DIV_SLOW        = 50000,
    parameter int unsigned DIV_FAST        = 50,
    parameter int unsigned CYC_WIDTH       = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 key_run,
    input  logic                 key_step,
    input  logic                 key_speed,
    input  logic                 halt_req,
    output logic                 cpu_ce,
    output logic                 running,
    output logic                 fast,
    output logic                 ce_led,
    output logic [CYC_WIDTH-1:0] cyc_count
);

    localparam logic [1:0] S_HALTED  = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_STEP    = 2'd2;

    localparam logic [DIV_WIDTH-1:0] C_TC_SLOW = DIV_WIDTH'(DIV_SLOW - 1);
    localparam logic [DIV_WIDTH-1:0] C_TC_FAST = DIV_WIDTH'(DIV_FAST - 1);
    localparam logic [DIV_WIDTH-1:0] C_DIV_ONE = DIV_WIDTH'(1);
    localparam logic [CYC_WIDTH-1:0] C_CYC_ONE = CYC_WIDTH'(1);

`ifndef CPU_CLOCK_CTRL_DEBOUNCE_EN
    // Debounce depth has no effect when the debouncers are removed.
    localparam int unsigned C_DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;
`endif

    // ------------------------------------------------------------------------
    // Key path: bit 0 = run, bit 1 = step, bit 2 = speed
    // ------------------------------------------------------------------------
    logic [2:0] w_key_raw;
    logic [2:0] w_key_press;
    logic       w_run_press;
    logic       w_step_press;
    logic       w_speed_press;

    assign w_key_raw     = {key_speed, key_step, key_run};
    assign w_run_press   = w_key_press[0];
    assign w_step_press  = w_key_press[1];
    assign w_speed_press = w_key_press[2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        logic sync1_q;
        logic sync2_q;
        logic stable_prev_q;
        logic press_q;
        logic w_stable;

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= w_key_raw[gi];
                sync2_q <= sync1_q;
            end
        end

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
        localparam int unsigned C_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);
        localparam logic [C_DB_W-1:0] C_DB_ONE  = C_DB_W'(1);

        logic [C_DB_W-1:0] db_cnt_q;
        logic [C_DB_W-1:0] db_cnt_d;
        logic              stable_q;
        logic              stable_d;

        // The counter tracks how many consecutive samples have disagreed
        // with the accepted level; any agreeing sample restarts it. The
        // DEBOUNCE_CYCLES-th disagreeing sample commits the new level.
        always_comb begin
            db_cnt_d = '0;
            stable_d = stable_q;
            if (sync2_q != stable_q) begin
                if (db_cnt_q == C_DB_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + C_DB_ONE;
                end
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                stable_q <= stable_d;
            end
        end

        assign w_stable = stable_q;
`else
        assign w_stable = sync2_q;
`endif

        // Registered rising-edge detect: only a 0->1 change is a press.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                stable_prev_q <= 1'b0;
                press_q       <= 1'b0;
            end else begin
                stable_prev_q <= w_stable;
                press_q       <= w_stable & ~stable_prev_q;
            end
        end

        assign w_key_press[gi] = press_q;
    end

    // ------------------------------------------------------------------------
    // Run/halt/step state machine and rate divider
    // ------------------------------------------------------------------------
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 fast_q;
    logic                 fast_d;
    logic                 ce_q;
    logic                 ce_d;
    logic                 running_q;
    logic                 led_q;
    logic [CYC_WIDTH-1:0] cyc_q;
    logic                 w_tc;

    assign w_tc = (div_q == (fast_q ? C_TC_FAST : C_TC_SLOW));

    // The divider rests at zero outside RUNNING, so entering or leaving
    // RUNNING and any speed toggle all restart a full DIV period.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        ce_d    = 1'b0;
        fast_d  = fast_q ^ w_speed_press;
        case (state_q)
            S_HALTED: begin
                if (!halt_req) begin
                    if (w_run_press) begin
                        state_d = S_RUNNING;
                    end else if (w_step_press) begin
                        state_d = S_STEP;
                        ce_d    = 1'b1;
                    end
                end
            end
            S_STEP: begin
                state_d = S_HALTED;
            end
            S_RUNNING: begin
                // Halt and run press win over the terminal count, and a
                // speed toggle restarts the period, swallowing that pulse.
                if (halt_req || w_run_press) begin
                    state_d = S_HALTED;
                end else if (w_speed_press) begin
                    div_d = '0;
                end else if (w_tc) begin
                    ce_d = 1'b1;
                end else begin
                    div_d = div_q + C_DIV_ONE;
                end
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_HALTED;
            div_q     <= '0;
            fast_q    <= 1'b0;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
            led_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            fast_q    <= fast_d;
            ce_q      <= ce_d;
            running_q <= (state_d == S_RUNNING);
            if (ce_q) begin
                led_q <= ~led_q;
                cyc_q <= cyc_q + C_CYC_ONE;
            end
        end
    end

    assign cpu_ce    = ce_q;
    assign running   = running_q;
    assign fast      = fast_q;
    assign ce_led    = led_q;
    assign cyc_count = cyc_q;

endmodule
`default_nettype wire
